// File: rtl/load_mc.sv
// -----------------------------------------------------------------------------
// load_mc : DRAM-to-buffer load engine for the GNN kernel.
//
// Takes one load instruction at a time. It issues a single read request to the
// AXI read master. It then streams the returned beats into one of NUM_BUF
// on-chip buffer write ports, chosen by a one-hot group field.
//
// Optional feature macro: LOAD_MC_BROADCAST_EN
//   undefined : the group must be exactly one-hot, otherwise the instruction
//               completes with ap_err=1 and no read is issued.
//   defined   : any nonzero group is legal. Each beat is written to every
//               selected port at the same address.
//
// Ports
//   kernel_clk, kernel_rst_n  clock, asynchronous active-low reset
//   inst_valid/inst_ready     instruction handshake (ready == engine idle)
//   inst_data                 [NUM_BUF-1:0] group, [32+:BUF_AW] buf_start,
//                             [63:48] len_beats, [95:64] dram_off
//   ctrl_addr_offset          DRAM base address, sampled at accept
//   rd_start/rd_addr/rd_size  one-cycle read request to the read master
//   rd_done                   read master completion pulse
//   data_t*                   returned beat stream
//   buf_wr_*                  per-port write strobe/accept, shared addr/data
//   ap_done/ap_err            completion pulse and error flag
// -----------------------------------------------------------------------------
module load_mc #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int LOAD_INST_LENGTH   = 128,
  parameter int NUM_BUF            = 5,
  parameter int BUF_AW             = 11
) (
  input  logic                          kernel_clk,
  input  logic                          kernel_rst_n,
  input  logic                          inst_valid,
  output logic                          inst_ready,
  input  logic [LOAD_INST_LENGTH-1:0]   inst_data,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  output logic                          rd_start,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] rd_addr,
  output logic [C_XFER_SIZE_WIDTH-1:0]  rd_size,
  input  logic                          rd_done,
  input  logic                          data_tvalid,
  output logic                          data_tready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] data_tdata,
  input  logic                          data_tlast,
  output logic [NUM_BUF-1:0]            buf_wr_valid,
  input  logic [NUM_BUF-1:0]            buf_wr_ready,
  output logic [BUF_AW-1:0]             buf_wr_addr,
  output logic [C_M_AXI_DATA_WIDTH-1:0] buf_wr_data,
  output logic                          ap_done,
  output logic                          ap_err
);

  localparam int LEN_W      = 16;
  localparam int BYTE_SHIFT = $clog2(C_M_AXI_DATA_WIDTH / 8);
  localparam int SZ_FULL_W  = C_XFER_SIZE_WIDTH + LEN_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_REQ    = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  // A group is legal when it is exactly one-hot, or nonzero when broadcast is built in.
  function automatic logic group_ok(input logic [NUM_BUF-1:0] g);
`ifdef LOAD_MC_BROADCAST_EN
    return (g != {NUM_BUF{1'b0}});
`else
    return $onehot(g);
`endif
  endfunction

  state_t                          r_state;
  state_t                          w_state_nxt;

  logic [NUM_BUF-1:0]              r_group;
  logic [LEN_W-1:0]                r_len;
  logic [LEN_W-1:0]                r_beat;
  logic [BUF_AW-1:0]               r_waddr;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_rd_addr;
  logic [C_XFER_SIZE_WIDTH-1:0]    r_rd_size;
  logic                            r_err;
  logic                            r_req_issued;
  logic                            r_rd_seen;
  logic [NUM_BUF-1:0]              r_wr_valid;
  logic [BUF_AW-1:0]               r_wr_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_wr_data;

  logic                            w_accept;
  logic                            w_beat_acc;
  logic                            w_last_beat;
  logic                            w_pend;
  logic [NUM_BUF-1:0]              w_remaining;
  logic                            w_fin_ok;
  logic                            w_err_set;
  logic [BUF_AW-1:0]               w_inst_buf_start;
  logic [LEN_W-1:0]                w_inst_len;
  logic [31:0]                     w_inst_off;
  logic [SZ_FULL_W-1:0]            w_size_full;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   w_rd_addr_calc;
  logic                            w_unused_inst;

  // Instruction field extraction; the reserved bits and gaps are deliberately ignored.
  assign w_inst_buf_start = inst_data[32+BUF_AW-1:32];
  assign w_inst_len       = inst_data[63:48];
  assign w_inst_off       = inst_data[95:64];
  assign w_unused_inst    = ^inst_data;

  assign w_rd_addr_calc = ctrl_addr_offset + C_M_AXI_ADDR_WIDTH'(w_inst_off);
  assign w_size_full    = {{C_XFER_SIZE_WIDTH{1'b0}}, w_inst_len} << BYTE_SHIFT;

  // Ports of the pending write that have still not seen ready this cycle.
  // For a one-hot group this is zero exactly when the single write retires.
  assign w_remaining = r_wr_valid & ~buf_wr_ready;
  assign w_pend      = |r_wr_valid;
  assign w_last_beat = (r_beat == (r_len - 16'd1));
  assign w_fin_ok    = ~w_pend & (r_rd_seen | ~r_req_issued);
  assign w_accept    = inst_valid & inst_ready;
  assign w_beat_acc  = (r_state == S_STREAM) & data_tvalid & data_tready;

  assign rd_addr      = r_rd_addr;
  assign rd_size      = r_rd_size;
  assign buf_wr_valid = r_wr_valid;
  assign buf_wr_addr  = r_wr_addr;
  assign buf_wr_data  = r_wr_data;

  // FSM state register.
  always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
    if (!kernel_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake/strobe outputs.
  always_comb begin
    w_state_nxt = r_state;
    inst_ready  = 1'b0;
    rd_start    = 1'b0;
    data_tready = 1'b0;
    ap_done     = 1'b0;
    ap_err      = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        inst_ready = 1'b1;
        if (inst_valid) begin
          w_state_nxt = S_CHECK;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CHECK: begin
        if (!group_ok(r_group)) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_FIN;
        end else if (r_len == 16'd0) begin
          w_state_nxt = S_FIN;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        rd_start    = 1'b1;
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        // A new beat may land in the output stage only if it is empty or
        // every still-selected port retires its write this cycle.
        data_tready = (w_remaining == {NUM_BUF{1'b0}});
        if (data_tvalid && data_tready) begin
          if (data_tlast && !w_last_beat) begin
            w_err_set   = 1'b1;
            w_state_nxt = S_FIN;
          end else if (!data_tlast && w_last_beat) begin
            w_err_set   = 1'b1;
            w_state_nxt = S_DRAIN;
          end else if (w_last_beat) begin
            w_state_nxt = S_FIN;
          end else begin
            w_state_nxt = S_STREAM;
          end
        end else begin
          w_state_nxt = S_STREAM;
        end
      end
      S_DRAIN: begin
        data_tready = 1'b1;
        if (data_tvalid && data_tlast) begin
          w_state_nxt = S_FIN;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_FIN: begin
        if (w_fin_ok) begin
          ap_done     = 1'b1;
          ap_err      = r_err;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_FIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Instruction fields and read request, captured at accept and held until the next one.
  always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
    if (!kernel_rst_n) begin
      r_group   <= {NUM_BUF{1'b0}};
      r_len     <= 16'd0;
      r_rd_addr <= {C_M_AXI_ADDR_WIDTH{1'b0}};
      r_rd_size <= {C_XFER_SIZE_WIDTH{1'b0}};
    end else if (w_accept) begin
      r_group   <= inst_data[NUM_BUF-1:0];
      r_len     <= w_inst_len;
      r_rd_addr <= w_rd_addr_calc;
      r_rd_size <= w_size_full[C_XFER_SIZE_WIDTH-1:0];
    end else begin
      r_group   <= r_group;
      r_len     <= r_len;
      r_rd_addr <= r_rd_addr;
      r_rd_size <= r_rd_size;
    end
  end

  // Error, request-issued and sticky rd_done flags for the current instruction.
  always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
    if (!kernel_rst_n) begin
      r_err        <= 1'b0;
      r_req_issued <= 1'b0;
      r_rd_seen    <= 1'b0;
    end else if (w_accept) begin
      r_err        <= 1'b0;
      r_req_issued <= 1'b0;
      r_rd_seen    <= 1'b0;
    end else begin
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (ap_done) begin
        r_err <= 1'b0;
      end else begin
        r_err <= r_err;
      end
      r_req_issued <= r_req_issued | rd_start;
      r_rd_seen    <= r_rd_seen | (rd_done & r_req_issued);
    end
  end

  // Beat counter and running buffer address; the address wraps modulo 2^BUF_AW.
  always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
    if (!kernel_rst_n) begin
      r_beat  <= 16'd0;
      r_waddr <= {BUF_AW{1'b0}};
    end else if (w_accept) begin
      r_beat  <= 16'd0;
      r_waddr <= w_inst_buf_start;
    end else if (w_beat_acc) begin
      r_beat  <= r_beat + 16'd1;
      r_waddr <= r_waddr + {{(BUF_AW-1){1'b0}}, 1'b1};
    end else begin
      r_beat  <= r_beat;
      r_waddr <= r_waddr;
    end
  end

  // Single registered write stage; each selected bit drops once its port accepts.
  always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
    if (!kernel_rst_n) begin
      r_wr_valid <= {NUM_BUF{1'b0}};
      r_wr_addr  <= {BUF_AW{1'b0}};
      r_wr_data  <= {C_M_AXI_DATA_WIDTH{1'b0}};
    end else if (w_beat_acc) begin
      r_wr_valid <= r_group;
      r_wr_addr  <= r_waddr;
      r_wr_data  <= data_tdata;
    end else begin
      r_wr_valid <= w_remaining;
      r_wr_addr  <= r_wr_addr;
      r_wr_data  <= r_wr_data;
    end
  end

endmodule

// File: doc/load_mc.md
Name: load_mc

Overview:
- Parametrised next-generation DRAM-to-buffer load engine for the GNN kernel.
- Accepts one load instruction at a time over a valid/ready handshake and issues a read request to the AXI read master.
- Streams the returned beats into one of NUM_BUF on-chip buffer write ports, selected by a one-hot group field.
- Adds over the previous loader: per-buffer write backpressure, buffer address wrap, zero-length handling, and error reporting for bad group and tlast mismatch.

Parameters:
- C_M_AXI_ADDR_WIDTH, 64, DRAM byte address width.
- C_M_AXI_DATA_WIDTH, 512, beat width in bits; power of two, at least 32.
- C_XFER_SIZE_WIDTH, 32, read request size width in bytes.
- LOAD_INST_LENGTH, 128, instruction width.
- NUM_BUF, 5, number of buffer write ports, 1..6.
- BUF_AW, 11, buffer word address width.

Ports:
- kernel_clk  in  1  sole clock
- kernel_rst_n  in  1  asynchronous active-low reset
- inst_valid  in  1  instruction offered
- inst_ready  out  1  engine idle; accepts the instruction
- inst_data  in  LOAD_INST_LENGTH  instruction; fields listed under Behaviour
- ctrl_addr_offset  in  C_M_AXI_ADDR_WIDTH  DRAM base address, sampled at accept
- rd_start  out  1  one-cycle read request pulse to the read master
- rd_addr  out  C_M_AXI_ADDR_WIDTH  request start byte address
- rd_size  out  C_XFER_SIZE_WIDTH  request size in bytes
- rd_done  in  1  read master completion pulse
- data_tvalid  in  1  returned beat valid
- data_tready  out  1  beat accepted
- data_tdata  in  C_M_AXI_DATA_WIDTH  returned beat
- data_tlast  in  1  last beat of the transfer
- buf_wr_valid  out  NUM_BUF  per-buffer write strobe
- buf_wr_ready  in  NUM_BUF  per-buffer write accept
- buf_wr_addr  out  BUF_AW  shared write address
- buf_wr_data  out  C_M_AXI_DATA_WIDTH  shared write data
- ap_done  out  1  one-cycle completion pulse
- ap_err  out  1  error flag, valid with ap_done

Behaviour:
- Reset: every output is 0 except inst_ready, which is 1. The FSM returns to IDLE and all counters clear. Reset mid-transfer abandons the transfer with no done pulse.
- Instruction fields:
  - group = inst[NUM_BUF-1:0]
  - buf_start = inst[32+BUF_AW-1:32]
  - len_beats = inst[63:48]
  - dram_off = inst[95:64]
  - inst[127:96] reserved, ignored
- Arithmetic:
  - rd_addr = ctrl_addr_offset + zero-extended dram_off.
  - rd_size = len_beats * (C_M_AXI_DATA_WIDTH/8), truncated to C_XFER_SIZE_WIDTH.
- FSM states: IDLE, CHECK, REQ, STREAM, DRAIN, FIN.
- IDLE: inst_ready=1. On inst_valid & inst_ready, register the fields and go to CHECK.
- CHECK (1 cycle):
  - group zero or not one-hot: set err, go to FIN, no rd_start.
  - len_beats==0: go to FIN with err=0, no rd_start.
  - Otherwise go to REQ.
- REQ: rd_start=1 for exactly one cycle with rd_addr/rd_size stable. Then go to STREAM. rd_addr/rd_size hold until the next accept.
- STREAM:
  - One registered output stage holds the pending write.
  - data_tready = !pend | buf_wr_ready[sel].
  - Accepted beat k (k from 0) sets pend with buf_wr_addr = (buf_start + k) mod 2^BUF_AW (wraps silently) and buf_wr_data = tdata.
  - buf_wr_valid[sel] stays high until buf_wr_ready[sel]; other bits stay 0.
  - Write latency: 1 cycle after the beat is accepted.
- tlast checks:
  - tlast on beat k < len_beats-1: set err; that beat is still written; leave STREAM after it.
  - Beat len_beats-1 without tlast: set err, go to DRAIN.
  - Otherwise leave STREAM after the last beat.
- DRAIN: data_tready=1, no writes, until a beat with tlast is accepted.
- FIN:
  - Waits for the final pending write to complete, and for rd_done (sticky, latched any time after rd_start; not required if no request was issued).
  - Then pulses ap_done for 1 cycle with ap_err, clears err, and returns to IDLE.
  - inst_ready rises in the cycle after ap_done.
- A write completing in the same cycle as the next beat is accepted gives full throughput of 1 beat per cycle.

Optional Feature:
- Macro: LOAD_MC_BROADCAST_EN.
- When defined:
  - A multi-hot nonzero group is legal.
  - Each beat asserts buf_wr_valid on all selected bits at the same address.
  - The pending write retires only once every selected port has seen ready; per-bit completion is tracked, and bits already accepted are dropped.
  - data_tready = !pend | all remaining selected ready.
- When undefined: a multi-hot group is an error, as in CHECK.

Test Plan:
- group=0b00100, buf_start=10, len=4, dram_off=0x40, offset=0x1000, all ready -> rd_start once with rd_addr=0x1040, rd_size=256. buf_wr_valid[2] on addrs 10..13 in consecutive cycles. ap_done with ap_err=0 after rd_done.
- buf_start=2046, len=4 -> write addresses 2046, 2047, 0, 1.
- buf_wr_ready[0] low for 3 cycles mid-stream, len=8 -> data_tready low in those cycles. Exactly 8 writes, in order, none duplicated.
- len=0 -> no rd_start, ap_done with ap_err=0 two cycles after accept. group=0b00011 without the macro -> no rd_start, ap_done with ap_err=1.
- len=4 with tlast on beat 1 -> 2 writes, ap_err=1. len=2 with tlast on beat 3 -> 2 writes, beats 2-3 drained, ap_err=1.
- kernel_rst_n low during STREAM -> all buf_wr_valid=0 immediately, inst_ready=1, no ap_done. The next instruction completes normally.
